// File: rtl/mul_16_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_16_seq_pkg
// Description : Shared definitions for the 16-bit sequential multiplier:
//               datapath widths, ALU control word, the ADD control
//               constant and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_16_seq_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    // Classic zx/nx/zy/ny/f/no ALU control word.
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    // x + y : no zeroing, no negation, adder selected, output not inverted.
    localparam alu_ctrl_t ALU_ADD = '{zx: 1'b0, nx: 1'b0, zy: 1'b0,
                                      ny: 1'b0, f: 1'b1, no: 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration index of the final (16th) doubling step.
    localparam logic [CNT_W-1:0] LAST_CNT = 5'd15;

endpackage
`default_nettype wire

// File: rtl/mul_16_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 16-bit combinational ALU (zx/nx/zy/ny/f/no style). Holds the
//               only adder of the multiplier datapath.
// Ports       : x, y  - operands
//               ctrl  - control word (alu_ctrl_t)
//               out   - result
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import mul_16_seq_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  alu_ctrl_t         ctrl,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] x_z;
    logic [DATA_W-1:0] x_n;
    logic [DATA_W-1:0] y_z;
    logic [DATA_W-1:0] y_n;
    logic [DATA_W-1:0] f_out;

    always_comb begin
        x_z   = ctrl.zx ? '0 : x;
        x_n   = ctrl.nx ? ~x_z : x_z;
        y_z   = ctrl.zy ? '0 : y;
        y_n   = ctrl.ny ? ~y_z : y_z;
        // Carry out of bit 15 is dropped: products wrap modulo 2^16.
        f_out = ctrl.f ? (x_n + y_n) : (x_n & y_n);
        out   = ctrl.no ? ~f_out : f_out;
    end

endmodule
`default_nettype wire

// File: rtl/mul_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_16_seq
// Description : 16x16 -> low-16 unsigned shift-and-add multiplier. One
//               shared ALU performs both the accumulate (ADD) and the
//               multiplicand doubling (DBL). Iterations stop as soon as the
//               remaining multiplier bits are all zero.
// Ports       : clk     - rising-edge clock
//               reset   - synchronous active-high reset
//               start   - begin a multiply (only honoured in IDLE)
//               a, b    - multiplicand / multiplier, captured on start
//               busy    - high in every state except IDLE
//               done    - one-cycle pulse, product valid
//               product - low 16 bits of a*b, held until the next done
//               zr, ng  - product == 0 / product[15]
// Revision    : 1.0 - initial release
// ============================================================================
module mul_16_seq
    import mul_16_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product,
    output logic              zr,
    output logic              ng
);

    state_t            state_q,   state_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic [DATA_W-1:0] mcand_q,   mcand_d;
    logic [DATA_W-1:0] mplier_q,  mplier_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic              zr_q,      zr_d;
    logic              ng_q,      ng_d;

    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_out;

    alu u_alu (
        .x    (alu_x),
        .y    (alu_y),
        .ctrl (ALU_ADD),
        .out  (alu_out)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        // ADD operands by default; DBL re-steers x to the multiplicand.
        alu_x     = acc_q;
        alu_y     = mcand_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    cnt_d    = '0;
                    state_d  = (b != '0) ? ADD : DONE;
                end
            end
            ADD: begin
                if (mplier_q[0]) begin
                    acc_d = alu_out;
                end
                state_d = DBL;
            end
            DBL: begin
                alu_x    = mcand_q;
                mcand_d  = alu_out;
                mplier_d = mplier_q >> 1;
                // Iteration counter only; the datapath sum goes through the ALU.
                cnt_d    = cnt_q + 5'd1;
                state_d  = ((mplier_q >> 1) == '0 || cnt_q == LAST_CNT) ? DONE : ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: they are loaded on the edge that enters
        // DONE so they are valid during the DONE cycle itself. Using acc_d
        // covers both the DBL exit and the b==0 shortcut from IDLE.
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        if (state_d == DONE) begin
            product_d = acc_d;
            zr_d      = (acc_d == '0);
            ng_d      = acc_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            zr_q      <= 1'b1;
            ng_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign zr      = zr_q;
    assign ng      = ng_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_16_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_16_seq
// Description : Directed self-checking bench for mul_16_seq. Cycle n is the
//               n-th clock period after the edge that samples start
//               (cycle 0 = sampling cycle); done is expected in 2k+1 for a
//               multiplier of bit length k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        zr;
    logic        ng;

    int n_tests;
    int n_fail;

    mul_16_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request; called just after a rising edge so the next edge
    // is the sampling edge (cycle 0).
    task automatic kick(input logic [15:0] a_v, input logic [15:0] b_v);
        a     = a_v;
        b     = b_v;
        start = 1'b1;
    endtask

    // Step cycles until done is seen; returns its cycle number or -1 when
    // the budget expires.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h want 0000", product); end
        n_tests++; if (zr !== 1'b1)          begin n_fail++; $display("FAIL reset_zr got %b want 1", zr); end
        n_tests++; if (ng !== 1'b0)          begin n_fail++; $display("FAIL reset_ng got %b want 0", ng); end
    endtask

    // 3*5 started on the very first edge after reset is released.
    task automatic test_basic;
        int c;
        reset = 1'b0;
        kick(16'd3, 16'd5);
        wait_done(c);
        n_tests++; if (c !== 7)              begin n_fail++; $display("FAIL basic_cycle got %0d want 7", c); end
        n_tests++; if (product !== 16'd15)   begin n_fail++; $display("FAIL basic_product got %h want 000f", product); end
        n_tests++; if (zr !== 1'b0)          begin n_fail++; $display("FAIL basic_zr got %b want 0", zr); end
        n_tests++; if (ng !== 1'b0)          begin n_fail++; $display("FAIL basic_ng got %b want 0", ng); end
        @(posedge clk); #1;
        n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
        n_tests++; if (product !== 16'd15)   begin n_fail++; $display("FAIL basic_hold got %h want 000f", product); end
    endtask

    task automatic test_max;
        int c;
        kick(16'hFFFF, 16'hFFFF);
        wait_done(c);
        n_tests++; if (c !== 33)             begin n_fail++; $display("FAIL max_cycle got %0d want 33", c); end
        n_tests++; if (product !== 16'h0001) begin n_fail++; $display("FAIL max_product got %h want 0001", product); end
        n_tests++; if (zr !== 1'b0)          begin n_fail++; $display("FAIL max_zr got %b want 0", zr); end
        n_tests++; if (ng !== 1'b0)          begin n_fail++; $display("FAIL max_ng got %b want 0", ng); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_b;
        int c;
        kick(16'h1234, 16'h0000);
        wait_done(c);
        n_tests++; if (c !== 1)              begin n_fail++; $display("FAIL zero_b_cycle got %0d want 1", c); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL zero_b_product got %h want 0000", product); end
        n_tests++; if (zr !== 1'b1)          begin n_fail++; $display("FAIL zero_b_zr got %b want 1", zr); end
        n_tests++; if (ng !== 1'b0)          begin n_fail++; $display("FAIL zero_b_ng got %b want 0", ng); end
        @(posedge clk); #1;
    endtask

    // 0x100*0x100 wraps to 0; a start in cycle 5 and one in the DONE cycle
    // must both be ignored.
    task automatic test_busy_ignore;
        int c;
        c = -1;
        kick(16'h0100, 16'h0100);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 5) begin
                a     = 16'h0003;
                b     = 16'h0003;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                c = n;
                break;
            end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_high cycle %0d got %b want 1", n, busy); end
        end
        n_tests++; if (c !== 19)             begin n_fail++; $display("FAIL busy_cycle got %0d want 19", c); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL busy_product got %h want 0000", product); end
        n_tests++; if (zr !== 1'b1)          begin n_fail++; $display("FAIL busy_zr got %b want 1", zr); end
        // Start during the DONE cycle: must not launch a new operation.
        a     = 16'h0005;
        b     = 16'h0005;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL done_cycle_start busy got %b want 0", busy); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL done_cycle_start busy2 got %b want 0", busy); end
    endtask

    // Reset in cycle 10 aborts 7*0xFFFF; a new 2*3 follows immediately.
    task automatic test_reset_abort;
        int c;
        int seen_done;
        seen_done = 0;
        kick(16'd7, 16'hFFFF);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) seen_done++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_tests++; if (product !== 16'h0000) begin n_fail++; $display("FAIL abort_product got %h want 0000", product); end
        n_tests++; if (zr !== 1'b1)          begin n_fail++; $display("FAIL abort_zr got %b want 1", zr); end
        n_tests++; if (seen_done !== 0)      begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", seen_done); end
        kick(16'd2, 16'd3);
        wait_done(c);
        n_tests++; if (c !== 5)              begin n_fail++; $display("FAIL abort_restart_cycle got %0d want 5", c); end
        n_tests++; if (product !== 16'd6)    begin n_fail++; $display("FAIL abort_restart_product got %h want 0006", product); end
        @(posedge clk); #1;
    endtask

    task automatic test_neg;
        int c;
        kick(16'h4000, 16'h0002);
        wait_done(c);
        n_tests++; if (c !== 5)              begin n_fail++; $display("FAIL neg_cycle got %0d want 5", c); end
        n_tests++; if (product !== 16'h8000) begin n_fail++; $display("FAIL neg_product got %h want 8000", product); end
        n_tests++; if (ng !== 1'b1)          begin n_fail++; $display("FAIL neg_ng got %b want 1", ng); end
        n_tests++; if (zr !== 1'b0)          begin n_fail++; $display("FAIL neg_zr got %b want 0", zr); end
        @(posedge clk); #1;
    endtask

    // Outputs from the previous multiply stay put while the next one runs.
    task automatic test_hold;
        int c;
        c = -1;
        kick(16'h0003, 16'h0004);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                c = n;
                break;
            end
            n_tests++; if (product !== 16'h8000 || ng !== 1'b1 || zr !== 1'b0)
                begin n_fail++; $display("FAIL hold cycle %0d got %h/%b/%b want 8000/1/0", n, product, ng, zr); end
        end
        n_tests++; if (c !== 7)              begin n_fail++; $display("FAIL hold_cycle got %0d want 7", c); end
        n_tests++; if (product !== 16'd12)   begin n_fail++; $display("FAIL hold_product got %h want 000c", product); end
        n_tests++; if (ng !== 1'b0)          begin n_fail++; $display("FAIL hold_ng got %b want 0", ng); end
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_basic;
        test_max;
        test_zero_b;
        test_busy_ignore;
        test_reset_abort;
        test_neg;
        test_hold;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_16_seq.md
MUL_16_SEQ -- requirements
Module: mul_16_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  16  multiplicand, captured on accepted start.
REQ-006 b  input  16  multiplier, captured on accepted start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when product is valid.
REQ-009 product  output  16  low 16 bits of a*b (unsigned; equals two's-complement low half); held from done until the next accepted start.
REQ-010 zr  output  1  product == 0, valid from done onward.
REQ-011 ng  output  1  product[15], valid from done onward.

Function
REQ-012 All additions SHALL be performed by one shared alu instance; no other adder is permitted in the block.
REQ-013 ALU control for every operation SHALL be zx=0, nx=0, zy=0, ny=0, f=1, no=0 (x+y).
REQ-014 Internal registers: acc[15:0], mcand[15:0], mplier[15:0], cnt[4:0], state.
REQ-015 States SHALL be IDLE, ADD, DBL, DONE.
REQ-016 IDLE: on start=1 -> acc=0, mcand=a, mplier=b, cnt=0; next state ADD if b!=0, else DONE.
REQ-017 ADD: ALU x=acc, y=mcand; if mplier[0]=1 then acc <= ALU out, else acc unchanged; next state DBL.
REQ-018 DBL: ALU x=mcand, y=mcand; mcand <= ALU out; mplier <= mplier>>1; cnt <= cnt+1.
REQ-019 DBL exit: next state DONE if (mplier>>1)==0 or cnt==15, else ADD.
REQ-020 DONE: done=1 for exactly one cycle; product, zr, ng update from acc; next state IDLE.
REQ-021 Latency: with the start-sampling cycle numbered 0 and k = bit length of b (0 for b=0), done SHALL be high in cycle 2k+1; the maximum is cycle 33.
REQ-022 start while busy=1 SHALL be ignored; the inputs a and b SHALL NOT be recaptured.
REQ-023 start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; start is accepted only when state==IDLE at the sampling edge.
REQ-024 Carries beyond bit 15 SHALL be discarded (wrap-around); there is no overflow flag.
REQ-025 product, zr and ng SHALL NOT change between DONE and the next DONE.

Reset
REQ-026 When reset=1 at a clock edge: state=IDLE, busy=0, done=0, product=0, zr=1, ng=0, acc=mcand=mplier=0, cnt=0.
REQ-027 Reset SHALL take precedence over start and over every in-flight state; an aborted operation produces no done pulse.
REQ-028 The first start SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-029 A shared include header (alu_defs.vh) SHALL hold the ALU control constant ALU_ADD (zx,nx,zy,ny,f,no = 0,0,0,0,1,0) and the state encodings IDLE=2'd0, ADD=2'd1, DBL=2'd2, DONE=2'd3.
REQ-030 Exactly one sub-module SHALL be instantiated: alu. The ALU x/y input muxing and the state register SHALL be local to mul_16_seq.

Verification
REQ-031 a=3, b=5, start pulse -> done in cycle 7, product=15, zr=0, ng=0.
REQ-032 a=0xFFFF, b=0xFFFF -> done in cycle 33, product=0x0001, zr=0, ng=0.
REQ-033 a=0x1234, b=0 -> done in cycle 1, product=0, zr=1, ng=0.
REQ-034 a=0x0100, b=0x0100 -> done in cycle 19, product=0x0000 (wrap), zr=1; a second start at cycle 5 is ignored and busy stays 1.
REQ-035 a=7, b=0xFFFF, reset=1 at cycle 10 -> next cycle busy=0, product=0, zr=1, no done pulse; a new start with a=2, b=3 -> done in cycle 5, product=6.
REQ-036 a=0x4000, b=2 -> done in cycle 5, product=0x8000, ng=1, zr=0.
